// File: rtl/ssg_pkg.sv
// Shared definitions for the seven-segment scan reader: segment patterns, blank pattern
// and the scan FSM state encoding.
package ssg_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StSample = 2'd2,
        StHold   = 2'd3
    } ssg_state_e;

    // Active-high segment patterns, bit 0 = a .. bit 6 = g
    localparam logic [6:0] SSG_0     = 7'h3F;
    localparam logic [6:0] SSG_1     = 7'h06;
    localparam logic [6:0] SSG_2     = 7'h5B;
    localparam logic [6:0] SSG_3     = 7'h4F;
    localparam logic [6:0] SSG_4     = 7'h66;
    localparam logic [6:0] SSG_5     = 7'h6D;
    localparam logic [6:0] SSG_6     = 7'h7D;
    localparam logic [6:0] SSG_7     = 7'h07;
    localparam logic [6:0] SSG_8     = 7'h7F;
    localparam logic [6:0] SSG_9     = 7'h6F;
    localparam logic [6:0] SSG_A     = 7'h77;
    localparam logic [6:0] SSG_B     = 7'h7C;
    localparam logic [6:0] SSG_C     = 7'h39;
    localparam logic [6:0] SSG_D     = 7'h5E;
    localparam logic [6:0] SSG_E     = 7'h79;
    localparam logic [6:0] SSG_F     = 7'h71;
    localparam logic [6:0] SSG_BLANK = 7'h00;

    function automatic logic [6:0] ssg_encode(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = SSG_0;
            4'h1: seg = SSG_1;
            4'h2: seg = SSG_2;
            4'h3: seg = SSG_3;
            4'h4: seg = SSG_4;
            4'h5: seg = SSG_5;
            4'h6: seg = SSG_6;
            4'h7: seg = SSG_7;
            4'h8: seg = SSG_8;
            4'h9: seg = SSG_9;
            4'hA: seg = SSG_A;
            4'hB: seg = SSG_B;
            4'hC: seg = SSG_C;
            4'hD: seg = SSG_D;
            4'hE: seg = SSG_E;
            default: seg = SSG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssg_pattern_decode.sv
// Combinational segment-pattern to hex decoder; flags blank and undefined patterns.
module ssg_pattern_decode
    import ssg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       hit,
    output logic       blank,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b1;
        blank  = 1'b0;
        nibble = 4'h0;
        case (pattern)
            SSG_0: nibble = 4'h0;
            SSG_1: nibble = 4'h1;
            SSG_2: nibble = 4'h2;
            SSG_3: nibble = 4'h3;
            SSG_4: nibble = 4'h4;
            SSG_5: nibble = 4'h5;
            SSG_6: nibble = 4'h6;
            SSG_7: nibble = 4'h7;
            SSG_8: nibble = 4'h8;
            SSG_9: nibble = 4'h9;
            SSG_A: nibble = 4'hA;
            SSG_B: nibble = 4'hB;
            SSG_C: nibble = 4'hC;
            SSG_D: nibble = 4'hD;
            SSG_E: nibble = 4'hE;
            SSG_F: nibble = 4'hF;
            SSG_BLANK: begin
                hit   = 1'b0;
                blank = 1'b1;
            end
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/ssg_scan_decoder.sv
// Reader for a multiplexed active-low seven-segment bus: recovers per-digit hex values and
// decimal points once a digit has been seen identically on enough settled scans.
module ssg_scan_decoder
    import ssg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned STABLE_SCANS  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   anode,
    input  logic [7:0]              cathode,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    output logic                    pattern_err,
    output logic                    overlap_err
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [2:0] STAB_MAX = 3'(STABLE_SCANS);

    logic [NUM_DIGITS-1:0] anode_s1_q, anode_s2_q;
    logic [7:0]            cath_s1_q, cath_s2_q;

    ssg_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0] anode_lat_q, anode_lat_d;
    logic [7:0]            cath_lat_q, cath_lat_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic [4:0]            cand_q [NUM_DIGITS];
    logic [2:0]            stab_q [NUM_DIGITS];
    logic [3:0]            digit_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dp_q, valid_q;
    logic                  multi_q, pattern_err_q, overlap_err_q;

    logic [NUM_DIGITS-1:0] low;
    logic                  multi, onehot;
    logic [IDX_W-1:0]      idx_sel;

    logic                  dec_hit, dec_blank;
    logic [3:0]            dec_nib;
    logic [4:0]            sample_val;
    logic [2:0]            stab_nx;

    // Both synchronisers idle at "all lines inactive" so reset never looks like an overlap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_s1_q <= '1;
            anode_s2_q <= '1;
            cath_s1_q  <= '1;
            cath_s2_q  <= '1;
        end else begin
            anode_s1_q <= anode;
            anode_s2_q <= anode_s1_q;
            cath_s1_q  <= cathode;
            cath_s2_q  <= cath_s1_q;
        end
    end

    assign low    = ~anode_s2_q;
    assign multi  = (low & (low - 1'b1)) != '0;
    assign onehot = (low != '0) && !multi;

    always_comb begin
        idx_sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (low[i]) idx_sel = IDX_W'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        anode_lat_d = anode_lat_q;
        cath_lat_d  = cath_lat_q;
        idx_d       = idx_q;
        case (state_q)
            StIdle: begin
                if (onehot) begin
                    state_d     = StSettle;
                    cnt_d       = '0;
                    anode_lat_d = anode_s2_q;
                    cath_lat_d  = cath_s2_q;
                    idx_d       = idx_sel;
                end
            end
            StSettle: begin
                if (anode_s2_q != anode_lat_q || cath_s2_q != cath_lat_q) begin
                    if (onehot) begin
                        cnt_d       = '0;
                        anode_lat_d = anode_s2_q;
                        cath_lat_d  = cath_s2_q;
                        idx_d       = idx_sel;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSample: state_d = StHold;
            StHold: begin
                // Only the anode vector matters here; the cathode is already captured
                if (anode_s2_q != anode_lat_q) begin
                    if (onehot) begin
                        state_d     = StSettle;
                        cnt_d       = '0;
                        anode_lat_d = anode_s2_q;
                        cath_lat_d  = cath_s2_q;
                        idx_d       = idx_sel;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            anode_lat_q <= '1;
            cath_lat_q  <= '1;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            anode_lat_q <= anode_lat_d;
            cath_lat_q  <= cath_lat_d;
            idx_q       <= idx_d;
        end
    end

    ssg_pattern_decode u_decode (
        .pattern (~cath_lat_q[6:0]),
        .hit     (dec_hit),
        .blank   (dec_blank),
        .nibble  (dec_nib)
    );

    assign sample_val = {~cath_lat_q[7], dec_nib};

    always_comb begin
        stab_nx = 3'd1;
        if (cand_q[idx_q] == sample_val) begin
            stab_nx = (stab_q[idx_q] >= STAB_MAX) ? STAB_MAX : stab_q[idx_q] + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cand_q[i]  <= '0;
                stab_q[i]  <= '0;
                digit_q[i] <= '0;
            end
            dp_q          <= '0;
            valid_q       <= '0;
            multi_q       <= 1'b0;
            pattern_err_q <= 1'b0;
            overlap_err_q <= 1'b0;
        end else begin
            multi_q       <= multi;
            overlap_err_q <= multi && !multi_q;
            pattern_err_q <= 1'b0;
            if (state_q == StSample) begin
                if (dec_hit) begin
                    cand_q[idx_q] <= sample_val;
                    stab_q[idx_q] <= stab_nx;
                    if (stab_nx == STAB_MAX) begin
                        digit_q[idx_q] <= dec_nib;
                        dp_q[idx_q]    <= sample_val[4];
                        valid_q[idx_q] <= 1'b1;
                    end
                end else if (dec_blank) begin
                    stab_q[idx_q]  <= '0;
                    valid_q[idx_q] <= 1'b0;
                end else begin
                    stab_q[idx_q] <= '0;
                    pattern_err_q <= 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digits
        assign digits[4*i +: 4] = digit_q[i];
    end

    assign dp          = dp_q;
    assign digit_valid = valid_q;
    assign frame_valid = &valid_q;
    assign pattern_err = pattern_err_q;
    assign overlap_err = overlap_err_q;

endmodule

// File: tb/tb_ssg_scan_decoder.sv
// Scoreboard bench for ssg_scan_decoder: each scan pushes its expected outcome, which is
// popped and compared once the digit has been released.
module tb_ssg_scan_decoder;

    localparam int STABLE = 2;

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  val;
        logic [3:0]  dpv;
        int          perr;
        int          ovl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  anode = 4'hF;
    logic [7:0]  cathode = 8'hFF;
    logic [15:0] digits;
    logic [3:0]  dp, digit_valid;
    logic        frame_valid, pattern_err, overlap_err;

    int n_checks = 0;
    int n_fail = 0;
    int perr_cnt = 0;
    int ovl_cnt = 0;

    logic [6:0]  seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [4:0]  m_cand [4];
    int          m_stab [4];
    logic [15:0] m_dig = '0;
    logic [3:0]  m_val = '0;
    logic [3:0]  m_dp = '0;
    exp_t        sb [$];

    ssg_scan_decoder #(
        .NUM_DIGITS    (4),
        .SETTLE_CYCLES (4),
        .STABLE_SCANS  (STABLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .anode       (anode),
        .cathode     (cathode),
        .digits      (digits),
        .dp          (dp),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .pattern_err (pattern_err),
        .overlap_err (overlap_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (pattern_err) perr_cnt++;
        if (overlap_err) ovl_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] hexc(input int v, input logic dpv);
        return ~{dpv, seg_tbl[v]};
    endfunction

    // Reference behaviour of one settled scan of digit d
    task automatic model_scan(input int d, input logic [7:0] cath, output int perr);
        logic [6:0] pat;
        logic [4:0] v5;
        int         hit;
        pat  = ~cath[6:0];
        hit  = -1;
        perr = 0;
        for (int v = 0; v < 16; v++) if (seg_tbl[v] == pat) hit = v;
        if (hit >= 0) begin
            v5 = {~cath[7], hit[3:0]};
            if (m_cand[d] == v5) begin
                if (m_stab[d] < STABLE) m_stab[d]++;
            end else begin
                m_cand[d] = v5;
                m_stab[d] = 1;
            end
            if (m_stab[d] == STABLE) begin
                m_dig[4*d +: 4] = hit[3:0];
                m_dp[d]  = v5[4];
                m_val[d] = 1'b1;
            end
        end else if (pat == 7'h00) begin
            m_val[d]  = 1'b0;
            m_stab[d] = 0;
        end else begin
            perr      = 1;
            m_stab[d] = 0;
        end
    endtask

    task automatic push_exp(input int perr, input int ovl);
        exp_t e;
        e.dig  = m_dig;
        e.val  = m_val;
        e.dpv  = m_dp;
        e.perr = perr;
        e.ovl  = ovl;
        sb.push_back(e);
    endtask

    task automatic pop_compare(input int p0, input int o0);
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check("digits", 32'(digits), 32'(e.dig));
        check("digit_valid", 32'(digit_valid), 32'(e.val));
        check("dp", 32'(dp), 32'(e.dpv));
        check("frame_valid", 32'(frame_valid), 32'(&e.val));
        check("pattern_err_pulses", 32'(perr_cnt - p0), 32'(e.perr));
        check("overlap_err_pulses", 32'(ovl_cnt - o0), 32'(e.ovl));
    endtask

    task automatic scan(input int d, input logic [7:0] cath);
        int pe, p0, o0;
        model_scan(d, cath, pe);
        push_exp(pe, 0);
        p0 = perr_cnt;
        o0 = ovl_cnt;
        anode   = ~(4'b0001 << d);
        cathode = cath;
        repeat (12) @(negedge clk);
        anode = 4'hF;
        repeat (3) @(negedge clk);
        pop_compare(p0, o0);
    endtask

    task automatic frame(input logic [7:0] c0, input logic [7:0] c1,
                         input logic [7:0] c2, input logic [7:0] c3);
        scan(0, c0);
        scan(1, c1);
        scan(2, c2);
        scan(3, c3);
    endtask

    initial begin
        int p0, o0;
        for (int i = 0; i < 4; i++) begin
            m_cand[i] = '0;
            m_stab[i] = 0;
        end

        repeat (3) @(negedge clk);
        check("rst_digits", 32'(digits), 32'd0);
        check("rst_valid", 32'(digit_valid), 32'd0);
        check("rst_dp", 32'(dp), 32'd0);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_pattern_err", 32'(pattern_err), 32'd0);
        check("rst_overlap_err", 32'(overlap_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Plain 1,2,3,4 scanning
        repeat (2) frame(hexc(1, 0), hexc(2, 0), hexc(3, 0), hexc(4, 0));
        check("frame1_digits", 32'(digits), 32'h4321);
        check("frame1_frame_valid", 32'(frame_valid), 32'd1);

        // Single glitched scan on digit 2 must not commit
        frame(hexc(1, 0), hexc(2, 0), hexc(5, 0), hexc(4, 0));
        frame(hexc(1, 0), hexc(2, 0), hexc(3, 0), hexc(4, 0));
        check("glitch_digits", 32'(digits), 32'h4321);

        // Decimal point on digit 3, then back off
        repeat (2) frame(hexc(1, 0), hexc(2, 0), hexc(3, 0), hexc(4, 1));
        check("dp_on", 32'(dp), 32'h8);
        repeat (2) frame(hexc(1, 0), hexc(2, 0), hexc(3, 0), hexc(4, 0));

        // Blank digit 0
        repeat (2) frame(8'hFF, hexc(2, 0), hexc(3, 0), hexc(4, 0));
        check("blank_valid", 32'(digit_valid), 32'hE);

        // Undefined pattern on digit 1
        repeat (2) frame(hexc(1, 0), ~8'h49, hexc(3, 0), hexc(4, 0));
        check("undef_digit1", 32'(digits[7:4]), 32'h2);

        // Two anodes low at once
        push_exp(0, 1);
        p0 = perr_cnt;
        o0 = ovl_cnt;
        anode   = 4'b1100;
        cathode = hexc(8, 0);
        repeat (10) @(negedge clk);
        anode = 4'hF;
        repeat (4) @(negedge clk);
        pop_compare(p0, o0);

        // Cathode never settles long enough to sample
        push_exp(0, 0);
        p0 = perr_cnt;
        o0 = ovl_cnt;
        anode = 4'b0111;
        for (int t = 0; t < 10; t++) begin
            cathode = (t % 2 == 0) ? hexc(7, 0) : hexc(9, 0);
            repeat (2) @(negedge clk);
        end
        pop_compare(p0, o0);

        // Asynchronous reset while still toggling
        cathode = hexc(7, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_digits", 32'(digits), 32'd0);
        check("arst_valid", 32'(digit_valid), 32'd0);
        check("arst_dp", 32'(dp), 32'd0);
        check("arst_frame_valid", 32'(frame_valid), 32'd0);
        check("arst_pattern_err", 32'(pattern_err), 32'd0);
        check("arst_overlap_err", 32'(overlap_err), 32'd0);
        anode = 4'hF;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
